// File: rtl/tpu_package.sv
// Shared TPU parameters and the weight-feeder state encoding.
// Lane width is W_WIDTH+1 bits; a tile is MUL_SIZE rows of MUL_SIZE lanes.
package tpu_package;

    localparam int MUL_SIZE        = 4;
    localparam int W_WIDTH         = 7;
    localparam int WMEM_ADDR_WIDTH = 12;
    localparam int TILE_CNT_WIDTH  = 9;
    localparam int ROW_CNT_WIDTH   = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        SEND,
        GAP,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/weight_feeder.sv
// Streams tiles of MUL_SIZE consecutive weight-memory rows into the weight FIFO,
// one tile per FIFO request, with registered read strobe and address.
module weight_feeder
    import tpu_package::*;
(
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [WMEM_ADDR_WIDTH-1:0]          base_addr_i,
    input  logic [TILE_CNT_WIDTH-1:0]           num_tiles_i,
    input  logic                                request_data_i,
    output logic                                mem_rd_en_o,
    output logic [WMEM_ADDR_WIDTH-1:0]          mem_addr_o,
    input  logic [MUL_SIZE-1:0][W_WIDTH:0]      mem_data_i,
    output logic                                sending_data_o,
    output logic [MUL_SIZE-1:0][W_WIDTH:0]      data_o,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam logic [ROW_CNT_WIDTH-1:0] ROW_LAST = ROW_CNT_WIDTH'(MUL_SIZE - 1);

    feeder_state_t                 state_reg,     state_next;
    logic [WMEM_ADDR_WIDTH-1:0]    cur_addr_reg,  cur_addr_next;
    logic [WMEM_ADDR_WIDTH-1:0]    mem_addr_reg,  mem_addr_next;
    logic [TILE_CNT_WIDTH-1:0]     num_tiles_reg, num_tiles_next;
    logic [TILE_CNT_WIDTH-1:0]     tile_cnt_reg,  tile_cnt_next;
    logic [ROW_CNT_WIDTH-1:0]      row_cnt_reg,   row_cnt_next;
    logic                          rd_en_reg,     rd_en_next;
    logic                          done_reg,      done_next;
    logic                          sending_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= IDLE;
            cur_addr_reg  <= '0;
            mem_addr_reg  <= '0;
            num_tiles_reg <= '0;
            tile_cnt_reg  <= '0;
            row_cnt_reg   <= '0;
            rd_en_reg     <= 1'b0;
            done_reg      <= 1'b0;
            sending_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_addr_reg  <= cur_addr_next;
            mem_addr_reg  <= mem_addr_next;
            num_tiles_reg <= num_tiles_next;
            tile_cnt_reg  <= tile_cnt_next;
            row_cnt_reg   <= row_cnt_next;
            rd_en_reg     <= rd_en_next;
            done_reg      <= done_next;
            // Memory returns data one cycle after the strobe, so valid follows it.
            sending_reg   <= rd_en_reg;
        end
    end

    // cur_addr_reg always holds the next row to fetch; mem_addr_reg the row on the bus.
    always_comb begin
        state_next     = state_reg;
        cur_addr_next  = cur_addr_reg;
        mem_addr_next  = mem_addr_reg;
        num_tiles_next = num_tiles_reg;
        tile_cnt_next  = tile_cnt_reg;
        row_cnt_next   = row_cnt_reg;
        rd_en_next     = 1'b0;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    cur_addr_next  = base_addr_i;
                    num_tiles_next = num_tiles_i;
                    tile_cnt_next  = '0;
                    row_cnt_next   = '0;
                    state_next     = (num_tiles_i == '0) ? DONE : WAIT_REQ;
                end
            end

            WAIT_REQ: begin
                if (request_data_i) begin
                    rd_en_next    = 1'b1;
                    mem_addr_next = cur_addr_reg;
                    cur_addr_next = cur_addr_reg + 12'd1;
                    row_cnt_next  = '0;
                    state_next    = SEND;
                end
            end

            SEND: begin
                // The tile runs to completion; request_data_i is not consulted here.
                if (row_cnt_reg == ROW_LAST) begin
                    tile_cnt_next = tile_cnt_reg + 9'd1;
                    state_next    = ((tile_cnt_reg + 9'd1) == num_tiles_reg) ? DONE : GAP;
                end else begin
                    rd_en_next    = 1'b1;
                    mem_addr_next = cur_addr_reg;
                    cur_addr_next = cur_addr_reg + 12'd1;
                    row_cnt_next  = row_cnt_reg + 1'b1;
                end
            end

            GAP: begin
                state_next = WAIT_REQ;
            end

            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mem_rd_en_o    = rd_en_reg;
    assign mem_addr_o     = mem_addr_reg;
    assign sending_data_o = sending_reg;
    assign busy_o         = (state_reg != IDLE);
    assign done_o         = done_reg;

    // Lanes are gated by the registered valid, so reset zeroes them at once.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_SIZE; gi++) begin : g_lane
            assign data_o[gi] = sending_reg ? mem_data_i[gi] : '0;
        end
    endgenerate

endmodule
